// File: rtl/sar_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sar_pkg                                                          |
// | Purpose  : Shared sample width, sample type and averager queue entry type.  |
// |            Entry carries min/max only when SAR_AVG_MINMAX_EN is defined.    |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
package sar_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t mean;
`ifdef SAR_AVG_MINMAX_EN
    sample_t min_v;
    sample_t max_v;
`endif
  } avg_entry_t;

`ifdef SAR_AVG_MINMAX_EN
  function automatic sample_t min_s(input sample_t a, input sample_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic sample_t max_s(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/sar_avg_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sar_avg_fifo                                                     |
// | Purpose  : Two-entry FIFO of averager results; a push into a full queue is  |
// |            accepted only when a pop happens on the same edge.               |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module sar_avg_fifo (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  sar_pkg::avg_entry_t push_data_i,
  input  logic                pop_i,
  output sar_pkg::avg_entry_t head_o,
  output logic                full_o,
  output logic                empty_o
);
  import sar_pkg::*;

  avg_entry_t mem_q [2];
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       w_pop;
  logic       w_push;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign head_o  = mem_q[rd_q];

  assign w_pop  = pop_i & ~empty_o;
  // When full, wr_q == rd_q: the new entry reuses the slot being popped.
  assign w_push = push_i & (~full_o | w_pop);

  always_comb begin
    rd_d  = rd_q ^ w_pop;
    wr_d  = wr_q ^ w_push;
    cnt_d = cnt_q;
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_q] <= push_data_i;
      end
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sar_sample_averager.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sar_sample_averager                                              |
// | Purpose  : Rounded mean over windows of 2^LOG2_N SAR samples, buffered in a |
// |            2-entry valid/ready queue with sticky overrun flag.              |
// |            Optional per-window min/max: define SAR_AVG_MINMAX_EN.           |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module sar_sample_averager #(
  parameter int LOG2_N   = 2,
  parameter int SAMPLE_W = sar_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic [SAMPLE_W-1:0] avg_data,
  output logic                overrun,
  input  logic                clear_overrun,
  output logic [SAMPLE_W-1:0] avg_min,
  output logic [SAMPLE_W-1:0] avg_max
);
  import sar_pkg::*;

  localparam int                ACC_W    = SAMPLE_W + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
  localparam logic [ACC_W-1:0]  ROUND    = ACC_W'(1) << (LOG2_N - 1);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic                res_valid_q, res_valid_d;
  avg_entry_t          res_q, res_d;
  logic                overrun_q, overrun_d;

  logic [ACC_W-1:0]    w_sum;
  logic [ACC_W-1:0]    w_rounded;
  logic [SAMPLE_W-1:0] w_mean;
  logic                w_close;
  avg_entry_t          w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_drop;

  // Sum plus half-LSB never exceeds N*2^SAMPLE_W - 1, so ACC_W bits suffice.
  assign w_sum     = acc_q + ACC_W'(sample_data);
  assign w_rounded = w_sum + ROUND;
  assign w_mean    = w_rounded[ACC_W-1:LOG2_N];
  assign w_close   = sample_valid & (cnt_q == CNT_LAST);

`ifdef SAR_AVG_MINMAX_EN
  sample_t min_q, min_d;
  sample_t max_q, max_d;
  sample_t w_win_min;
  sample_t w_win_max;

  assign w_win_min = (cnt_q == '0) ? sample_data : min_s(min_q, sample_data);
  assign w_win_max = (cnt_q == '0) ? sample_data : max_s(max_q, sample_data);

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (sample_valid) begin
      min_d = w_win_min;
      max_d = w_win_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end
`endif

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_valid_d = w_close;
    res_d       = res_q;
    if (sample_valid) begin
      if (w_close) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = w_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (w_close) begin
      res_d.mean = w_mean;
`ifdef SAR_AVG_MINMAX_EN
      res_d.min_v = w_win_min;
      res_d.max_v = w_win_max;
`endif
    end
  end

  assign w_pop  = ~w_empty & avg_ready;
  assign w_drop = res_valid_q & w_full & ~w_pop;

  always_comb begin
    overrun_d = overrun_q;
    if (clear_overrun) overrun_d = 1'b0;
    if (w_drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      overrun_q   <= overrun_d;
    end
  end

  sar_avg_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (res_valid_q),
    .push_data_i (res_q),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  assign avg_valid = ~w_empty;
  assign avg_data  = w_head.mean;
  assign overrun   = overrun_q;
`ifdef SAR_AVG_MINMAX_EN
  assign avg_min   = w_head.min_v;
  assign avg_max   = w_head.max_v;
`else
  assign avg_min   = '0;
  assign avg_max   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sar_sample_averager.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_sar_sample_averager                                           |
// | Purpose  : Scoreboard bench for sar_sample_averager (LOG2_N=2), directed    |
// |            scenarios then random traffic; honours SAR_AVG_MINMAX_EN.        |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_sar_sample_averager;

  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       avg_valid;
  logic       avg_ready;
  logic [7:0] avg_data;
  logic       overrun;
  logic       clear_overrun;
  logic [7:0] avg_min;
  logic [7:0] avg_max;

  sar_sample_averager #(.LOG2_N(LOG2_N), .SAMPLE_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .avg_valid     (avg_valid),
    .avg_ready     (avg_ready),
    .avg_data      (avg_data),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .avg_min       (avg_min),
    .avg_max       (avg_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mean;
    int mn;
    int mx;
  } exp_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t mq[$];
  int   win[$];
  bit   m_pend = 1'b0;
  exp_t m_pend_e;
  bit   m_ovr  = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t window_result();
    exp_t e;
    int   sum = 0;
    int   mn  = 255;
    int   mx  = 0;
    foreach (win[i]) begin
      sum += win[i];
      if (win[i] < mn) mn = win[i];
      if (win[i] > mx) mx = win[i];
    end
    e.mean = (sum + N / 2) / N;
`ifdef SAR_AVG_MINMAX_EN
    e.mn = mn;
    e.mx = mx;
`else
    e.mn = 0;
    e.mx = 0;
`endif
    return e;
  endfunction

  // Reference: a closed window becomes available to the queue one edge later.
  always @(posedge clk) begin
    if (rst) begin
      win.delete();
      mq.delete();
      m_pend = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      if (clear_overrun) m_ovr = 1'b0;
      if (m_pend) begin
        if (mq.size() == 2) m_ovr = 1'b1;
        else mq.push_back(m_pend_e);
      end
      m_pend = 1'b0;
      if (sample_valid) begin
        win.push_back(int'(sample_data));
        if (win.size() == N) begin
          m_pend_e = window_result();
          m_pend   = 1'b1;
          win.delete();
        end
      end
    end
  end

  // Monitor: compare head against expectation, retire it on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("avg_valid", int'(avg_valid), int'(mq.size() != 0));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (mq.size() != 0) begin
        chk("avg_data", int'(avg_data), mq[0].mean);
        chk("avg_min", int'(avg_min), mq[0].mn);
        chk("avg_max", int'(avg_max), mq[0].mx);
        if (avg_ready) void'(mq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    sample_valid = 1'b1;
    sample_data  = 8'(d);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  // Expects avg_ready=1: result shows in the second cycle after the last strobe.
  task automatic window_check(input string name, input int a, input int b,
                              input int c, input int d, input int exp);
    send4(a, b, c, d);
    tick();
    chk({name, "_valid"}, int'(avg_valid), 1);
    chk(name, int'(avg_data), exp);
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    sample_valid  = 1'b0;
    sample_data   = 8'd0;
    avg_ready     = 1'b0;
    clear_overrun = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_valid", int'(avg_valid), 0);
    chk("rst_data", int'(avg_data), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_min", int'(avg_min), 0);
    chk("rst_max", int'(avg_max), 0);
    rst = 1'b0;

    // Latency: nothing in the cycle after the closing strobe, result in the next.
    avg_ready = 1'b1;
    send4(10, 20, 30, 40);
    chk("lat_c1_valid", int'(avg_valid), 0);
    tick();
    chk("lat_c2_valid", int'(avg_valid), 1);
    chk("mean_25", int'(avg_data), 25);
    tick();

    window_check("mean_255", 255, 255, 255, 255, 255);
    window_check("mean_0", 0, 0, 0, 0, 0);
    window_check("round_down", 1, 1, 1, 2, 1);
    window_check("round_up", 1, 2, 2, 2, 2);

    // Back-pressure: third window has nowhere to go.
    avg_ready = 1'b0;
    send4(5, 5, 5, 5);
    send4(6, 6, 6, 6);
    send4(7, 7, 7, 7);
    tick();
    tick();
    chk("bp_overrun", int'(overrun), 1);
    chk("bp_head5", int'(avg_data), 5);
    avg_ready = 1'b1;
    tick();
    chk("bp_head6", int'(avg_data), 6);
    tick();
    chk("bp_empty", int'(avg_valid), 0);
    avg_ready     = 1'b0;
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("bp_cleared", int'(overrun), 0);

    // Push and pop land on the same edge while full.
    send4(11, 11, 11, 11);
    send4(12, 12, 12, 12);
    tick();
    tick();
    send4(13, 13, 13, 13);
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    chk("pp_overrun", int'(overrun), 0);
    chk("pp_head12", int'(avg_data), 12);
    avg_ready = 1'b1;
    tick();
    chk("pp_head13", int'(avg_data), 13);
    tick();
    chk("pp_empty", int'(avg_valid), 0);

    // Mid-window reset discards the partial window.
    send(100);
    send(100);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", int'(avg_valid), 0);
    chk("mid_rst_data", int'(avg_data), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    window_check("after_rst", 8, 8, 8, 8, 8);

    send4(10, 40, 20, 30);
    tick();
    chk("mm_mean", int'(avg_data), 25);
`ifdef SAR_AVG_MINMAX_EN
    chk("mm_min", int'(avg_min), 10);
    chk("mm_max", int'(avg_max), 40);
`else
    chk("mm_min_tied", int'(avg_min), 0);
    chk("mm_max_tied", int'(avg_max), 0);
`endif
    tick();

    // Random traffic: scarce ready first to provoke overruns, then plentiful.
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom % 150) == 0;
      sample_valid  = ($urandom % 4) != 0;
      sample_data   = 8'($urandom);
      avg_ready     = (i < 300) ? (($urandom % 5) == 0) : (($urandom % 3) != 0);
      clear_overrun = ($urandom % 25) == 0;
      tick();
    end
    rst           = 1'b0;
    sample_valid  = 1'b0;
    clear_overrun = 1'b0;
    avg_ready     = 1'b1;
    repeat (10) tick();
    chk("drain_empty", int'(avg_valid), 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
